// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port data memory between two requesters.
// Optional owner locking with a bounded grant count is enabled by DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  logic          last_q, last_d;
  logic          rvalid0_q, rvalid1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          rd0, rd1;
`ifdef DMEM_ARB_LOCK_EN
  logic       own_v_q, own_v_d, own_q, own_d, blk;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] lk;
  assign lk  = {lock1, lock0};
  // a live owner excludes the other port; its count never reaches MAX_LOCK while owned
  assign blk = own_v_q & lk[own_q];
  assign gnt0 = rst_n & req0 & (blk ? ~own_q : (~req1 | last_q));
  assign gnt1 = rst_n & req1 & (blk ? own_q : (~req0 | ~last_q));
  always_comb begin
    own_v_d = own_v_q & lk[own_q];
    own_d = own_q;
    cnt_d = cnt_q;
    if (gnt0 | gnt1) begin
      if (lk[gnt1]) begin
        cnt_d = (own_v_d && own_q == gnt1) ? cnt_q + 4'd1 : 4'd1;
        own_d = gnt1;
        own_v_d = cnt_d != 4'(MAX_LOCK);
      end else if (own_q == gnt1) begin
        own_v_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      own_v_q <= 1'b0;
      own_q <= 1'b0;
      cnt_q <= 4'd0;
    end else begin
      own_v_q <= own_v_d;
      own_q <= own_d;
      cnt_q <= cnt_d;
    end
  end
`else
  assign gnt0 = rst_n & req0 & (~req1 | last_q);
  assign gnt1 = rst_n & req1 & (~req0 | ~last_q);
`endif
  assign rd0 = gnt0 & ~we0;
  assign rd1 = gnt1 & ~we1;
  assign last_d = gnt0 ? 1'b0 : gnt1 ? 1'b1 : last_q;
  assign mem_read = rd0 | rd1;
  assign mem_write = (gnt0 & we0) | (gnt1 & we1);
  assign mem_address = gnt0 ? addr0 : gnt1 ? addr1 : '0;
  assign mem_wdata = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      last_q <= last_d;
      rvalid0_q <= rd0;
      rvalid1_q <= rd1;
      if (rd0) rdata0_q <= mem_rdata;
      if (rd1) rdata1_q <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural 256x8 data memory.
// Lock scenario is compiled only with DMEM_ARB_LOCK_EN.
module tb_dmem_arbiter;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [7:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write;
  logic [7:0] rdata0, rdata1, mem_address, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic lock0 = 0, lock1 = 0;
`endif
  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
`ifdef DMEM_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  // unwritten locations read as address ^ 0x5A
  bit [7:0] mem [256];
  bit written [256];
  assign mem_rdata = written[mem_address] ? mem[mem_address] : (mem_address ^ 8'h5A);
  always @(posedge clk) if (mem_write) begin
    mem[mem_address] <= mem_wdata;
    written[mem_address] <= 1'b1;
  end
  int checks = 0, errors = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic exp_last = 1;
  int n0, n1;

  task automatic drive(input logic r0, w0, input logic [7:0] a0, d0, input logic r1, w1, input logic [7:0] a1, d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic r0, w0, input logic [7:0] a0, d0, input logic r1, w1, input logic [7:0] a1, d1,
                       output logic eg0, output logic eg1);
    eg0 = r0 && (!r1 || exp_last);
    eg1 = r1 && !eg0;
    if (eg0) begin
      exp_last = 0;
      if (w0) ref_mem[a0] = d0; else q0.push_back(ref_mem[a0]);
    end
    if (eg1) begin
      exp_last = 1;
      if (w1) ref_mem[a1] = d1; else q1.push_back(ref_mem[a1]);
    end
  endtask

  task automatic do_reset;
    rst_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    rst_n = 1;
    exp_last = 1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    drive(1, 0, 8'h05, 0, 1, 0, 8'h06, 0);
    tick;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_read, mem_write, rvalid0, rvalid1} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt0=%b gnt1=%b rd=%b wr=%b rv0=%b rv1=%b, all required 0", gnt0, gnt1, mem_read, mem_write, rvalid0, rvalid1);
    end
    checks++;
    if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata: rdata0=%h rdata1=%h, required 00 00", rdata0, rdata1);
    end
    tick;
    rst_n = 1;
    exp_last = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_write_read;
    logic eg0, eg1;
    drive(1, 1, 8'h10, 8'hA5, 0, 0, 0, 0);
    @(negedge clk);
    model(1, 1, 8'h10, 8'hA5, 0, 0, 0, 0, eg0, eg1);
    checks++;
    if (gnt0 !== eg0 || gnt1 !== eg1 || mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 8'h10 || mem_wdata !== 8'hA5) begin
      errors++;
      $display("FAIL wr_cycle: gnt0=%b gnt1=%b wr=%b rd=%b a=%h d=%h, required %b %b 1 0 10 a5", gnt0, gnt1, mem_write, mem_read, mem_address, mem_wdata, eg0, eg1);
    end
    tick;
    drive(1, 0, 8'h10, 0, 0, 0, 0, 0);
    @(negedge clk);
    model(1, 0, 8'h10, 0, 0, 0, 0, 0, eg0, eg1);
    checks++;
    if (gnt0 !== eg0 || mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 8'h10 || rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL rd_cycle: gnt0=%b rd=%b wr=%b a=%h rv0=%b, required %b 1 0 10 0", gnt0, mem_read, mem_write, mem_address, rvalid0, eg0);
    end
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'hA5) begin
      errors++;
      $display("FAIL rd_resp: rvalid0=%b rdata0=%h, required 1 a5", rvalid0, rdata0);
    end
    if (rvalid0 && q0.size() > 0) void'(q0.pop_front());
    tick;
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1'b0 || rdata0 !== 8'hA5) begin
      errors++;
      $display("FAIL rd_hold: rvalid0=%b rdata0=%h, required 0 a5", rvalid0, rdata0);
    end
    tick;
  endtask

  task automatic test_fairness;
    logic eg0, eg1;
    logic [7:0] e;
    do_reset;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) drive(1, 0, 8'h01, 0, 1, 0, 8'h02, 0); else drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (i < 6) begin
        model(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, eg0, eg1);
        checks++;
        if (gnt0 !== eg0 || gnt1 !== eg1 || eg0 !== (i % 2 == 0)) begin
          errors++;
          $display("FAIL rr_gnt[%0d]: gnt0=%b gnt1=%b, required %b %b", i, gnt0, gnt1, i % 2 == 0, i % 2 != 0);
        end
      end
      if (rvalid0) begin
        n0++;
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL rr_rv0[%0d]: strobe with no read outstanding", i);
        end else begin
          e = q0.pop_front();
          if (rdata0 !== e) begin errors++; $display("FAIL rr_rd0[%0d]: rdata0=%h required %h", i, rdata0, e); end
        end
      end
      if (rvalid1) begin
        n1++;
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL rr_rv1[%0d]: strobe with no read outstanding", i);
        end else begin
          e = q1.pop_front();
          if (rdata1 !== e) begin errors++; $display("FAIL rr_rd1[%0d]: rdata1=%h required %h", i, rdata1, e); end
        end
      end
      tick;
    end
    checks++;
    if (n0 != 3 || n1 != 3 || q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL rr_strobes: rvalid0 x%0d rvalid1 x%0d pending %0d/%0d, required 3 3 0/0", n0, n1, q0.size(), q1.size());
    end
  endtask

  task automatic test_raw;
    logic eg0, eg1;
    logic [7:0] e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(0, 0, 0, 0, 1, 1, 8'h80, 8'h3C);
        1: drive(1, 0, 8'h80, 0, 0, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      @(negedge clk);
      model(req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, eg0, eg1);
      checks++;
      if (gnt0 !== eg0 || gnt1 !== eg1) begin
        errors++;
        $display("FAIL raw_gnt[%0d]: gnt0=%b gnt1=%b, required %b %b", i, gnt0, gnt1, eg0, eg1);
      end
      checks++;
      if (rvalid1 !== 1'b0) begin errors++; $display("FAIL raw_rv1[%0d]: rvalid1=%b required 0", i, rvalid1); end
      if (rvalid0) begin
        checks++;
        e = (q0.size() > 0) ? q0.pop_front() : 8'hxx;
        if (rdata0 !== e || e !== 8'h3C) begin errors++; $display("FAIL raw_rd0: rdata0=%h required 3c", rdata0); end
      end
      tick;
    end
    checks++;
    if (q0.size() != 0) begin errors++; $display("FAIL raw_pending: %0d reads without rvalid0, required 0", q0.size()); end
  endtask

  task automatic test_idle;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, mem_read, mem_write, rvalid0, rvalid1} !== 6'b0 || mem_address !== 8'h00 || mem_wdata !== 8'h00) begin
        errors++;
        $display("FAIL idle[%0d]: gnt=%b%b rd=%b wr=%b rv=%b%b a=%h d=%h, all required 0", i, gnt0, gnt1, mem_read, mem_write, rvalid0, rvalid1, mem_address, mem_wdata);
      end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    logic eg0, eg1;
    logic [7:0] e;
    drive(1, 1, 8'h20, 8'hFF, 0, 0, 0, 0);
    rst_n = 0;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_gnt: gnt0=%b mem_write=%b, required 0 0", gnt0, mem_write);
    end
    tick;
    rst_n = 1;
    exp_last = 1;
    for (int i = 0; i < 4; i++) begin
      if (i < 2) drive(1, 0, 8'h20, 0, 1, 0, 8'h21, 0); else drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      model(req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, eg0, eg1);
      if (i < 2) begin
        checks++;
        if (gnt0 !== (i == 0) || gnt1 !== (i == 1)) begin
          errors++;
          $display("FAIL rstmid_first[%0d]: gnt0=%b gnt1=%b, required %b %b", i, gnt0, gnt1, i == 0, i == 1);
        end
      end
      if (rvalid0) begin
        checks++;
        e = (q0.size() > 0) ? q0.pop_front() : 8'hxx;
        if (rdata0 !== e || rdata0 !== 8'h7A) begin errors++; $display("FAIL rstmid_old: rdata0=%h required 7a", rdata0); end
      end
      if (rvalid1) begin
        checks++;
        e = (q1.size() > 0) ? q1.pop_front() : 8'hxx;
        if (rdata1 !== e) begin errors++; $display("FAIL rstmid_rd1: rdata1=%h required %h", rdata1, e); end
      end
      tick;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL rstmid_pending: %0d/%0d reads without rvalid, required 0/0", q0.size(), q1.size());
    end
  endtask

`ifdef DMEM_ARB_LOCK_EN
  task automatic test_lock;
    logic [7:0] r0 = 8'b1111_1101, r1 = 8'b1111_1110, l0 = 8'b0111_1111;
    logic [7:0] g0 = 8'b0101_1101, g1 = 8'b1010_0000;
    do_reset;
    for (int i = 0; i < 8; i++) begin
      drive(r0[i], 0, 8'h30, 0, r1[i], 0, 8'h31, 0);
      lock0 = l0[i];
      @(negedge clk);
      checks++;
      if (gnt0 !== g0[i] || gnt1 !== g1[i]) begin
        errors++;
        $display("FAIL lock_gnt[%0d]: gnt0=%b gnt1=%b, required %b %b", i, gnt0, gnt1, g0[i], g1[i]);
      end
      tick;
    end
    lock0 = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    test_reset;
    test_write_read;
    test_fairness;
    test_raw;
    test_idle;
    test_reset_mid;
`ifdef DMEM_ARB_LOCK_EN
    test_lock;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter that shares the single-port 256x8 data memory between requester 0 (CPU load/store unit) and requester 1 (crypto engine key/state fetch).
- Sits directly in front of the data memory. Drives its read-enable, write-enable, address and write-data lines, and samples its combinational read-data output.
- At most one memory access per cycle. Read data is returned to the winning requester through a registered response with a valid strobe.

Parameters:
- AW, 8, address width; must match data memory depth (2^AW bytes).
- DW, 8, data width.
- MAX_LOCK, 4, maximum consecutive grants to one locked owner (used only with the optional feature); legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0  in  1  requester 0 access request; must hold we0/addr0/wdata0 stable while req0=1 and gnt0=0.
- we0  in  1  1 = write, 0 = read.
- addr0  in  AW  byte address.
- wdata0  in  DW  write data.
- gnt0  out  1  access accepted this cycle (combinational).
- rvalid0  out  1  one-cycle strobe: rdata0 holds read result.
- rdata0  out  DW  registered read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for requester 1.
- mem_read  out  1  to data memory read enable.
- mem_write  out  1  to data memory write enable.
- mem_address  out  AW  to data memory address.
- mem_wdata  out  DW  to data memory write data.
- mem_rdata  in  DW  from data memory read data (combinational from mem_address).

Behaviour:
- Clock/reset: single clock clk. Reset rst_n is synchronous and active-low.
- Reset values: gnt0=gnt1=0, rvalid0=rvalid1=0, rdata0=rdata1=0, last_gnt=1 (so port 0 wins the first contention), lock state cleared.
- Arbitration is combinational from req0/req1 and the last_gnt register:
  - Only one port requesting: that port is granted.
  - Both requesting: the port not equal to last_gnt is granted.
  - Neither requesting: no grant.
- A transfer occurs in any cycle where reqN=1 and gntN=1. last_gnt updates to N at that clock edge.
- Memory drive:
  - Granted port's address/data are muxed onto mem_address/mem_wdata.
  - mem_write = granted and weN=1. mem_read = granted and weN=0.
  - With no grant, all memory outputs are 0.
- Write latency: data is committed by the memory at the same rising edge as the grant. No response strobe.
- Read latency: mem_rdata is sampled into rdataN at the grant edge. rvalidN=1 for exactly the following cycle.
  - rdataN holds its value until the next read on that port.
  - A back-to-back read on the same port gives an rvalid strobe every cycle.
- Read-after-write: a write by one port followed by a read of the same address in the next cycle (either port) returns the new data.
- Fairness: with both ports requesting continuously, grants alternate every cycle (0,1,0,1...). Each port receives ≥1 grant per 2 cycles.
- Reset asserted mid-operation: any grant in that cycle is suppressed (no mem_write). Pending rvalid strobes are cleared. last_gnt returns to 1.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- When defined:
  - Adds inputs lock0 and lock1 (1 bit each).
  - If a port is granted with lockN=1, it becomes owner. The other port receives no grant while the owner holds lockN=1 and the owner's consecutive-grant count is below MAX_LOCK.
  - Owner idle cycles (reqN=0, lockN=1) still block the other port but do not increment the count.
  - Ownership ends when lockN drops or when MAX_LOCK grants are reached.
  - On a forced release with the other port requesting, the other port is granted on the next cycle before the owner may re-lock.
- When not defined: lock ports and counter are absent; plain round-robin only.

Test Plan:
- Reset then req0 write addr 0x10 data 0xA5, next cycle req0 read 0x10 -> gnt0 both cycles, mem_write=1 then mem_read=1, rvalid0=1 with rdata0=0xA5 on the cycle after the read.
- req0 and req1 both held high for 6 cycles, reads of 0x01 and 0x02 -> gnt sequence 0,1,0,1,0,1; three rvalid0 and three rvalid1 strobes, interleaved.
- Port 1 writes 0x3C to 0x80, next cycle port 0 reads 0x80 -> rdata0=0x3C, rvalid1 never asserted.
- No requests for 3 cycles -> mem_read=mem_write=0, mem_address=0, no gnt/rvalid.
- rst_n driven low in the same cycle as a granted write of 0xFF to 0x20 -> memory at 0x20 unchanged; after reset, a read of 0x20 returns its old value; first contention goes to port 0.
- DMEM_ARB_LOCK_EN, MAX_LOCK=4: port 0 with lock0=1 requesting continuously, port 1 requesting -> gnt0 for 4 cycles, then gnt1 for 1 cycle, then port 0 resumes.
